hazard_ctrl_unit: RTL

Parametrised pipeline hazard controller for the 5-stage core; the successor to the single-cycle load-use hazard unit. It detects load-use hazards across `NSRC` decode source registers and stalls for a configurable `LOAD_LAT` cycles using a stall FSM. It also freezes the whole pipeline on data-memory wait, bubbles IF/ID on instruction-memory miss, flushes on taken branch/jump, and keeps a free-running stall-cycle performance counter. It sits beside the datapath and drives every pipeline-register write/flush enable and the PC write enable.

---
 rtl/hazard_ctrl_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall FSM, D-mem freeze, I-miss bubble, branch flush.
// Enables are combinational from state and current inputs; stall_cnt is registered.
module hazard_ctrl_unit #(
   parameter int NSRC     = 2,
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  MemRead_EX,
   input  logic [REG_W-1:0]      wsel_EX,
   input  logic [NSRC*REG_W-1:0] rsel_ID,
   input  logic [NSRC-1:0]       rsel_vld_ID,
   input  logic                  branch_taken_EX,
   input  logic                  ihit,
   input  logic                  dmem_req,
   input  logic                  dhit,
   output logic                  PCWrite,
   output logic                  Write_IF_ID,
   output logic                  Write_ID_EX,
   output logic                  Write_EX_MEM,
   output logic                  Write_MEM_WB,
   output logic                  flush_IF_ID,
   output logic                  ctrlFlush,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int CW = ($clog2(LOAD_LAT + 1) < 1) ? 1 : $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(LOAD_LAT - 1);

   typedef enum logic {RUN, LU_STALL} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_dwait;
   logic w_src_match;
   logic w_lu_hit;
   logic w_lu_stall;

   assign w_dwait = dmem_req & ~dhit;

   always_comb begin
      w_src_match = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (rsel_vld_ID[i] && (rsel_ID[i*REG_W +: REG_W] == wsel_EX))
            w_src_match = 1'b1;
      end
   end

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign w_lu_hit   = MemRead_EX & (wsel_EX != '0) & w_src_match;
   assign w_lu_stall = (r_state == LU_STALL) | w_lu_hit;

   always_comb begin
      PCWrite      = 1'b1;
      Write_IF_ID  = 1'b1;
      Write_ID_EX  = 1'b1;
      Write_EX_MEM = 1'b1;
      Write_MEM_WB = 1'b1;
      flush_IF_ID  = 1'b0;
      ctrlFlush    = 1'b0;
      if (RST) begin
         PCWrite      = 1'b0;
         Write_IF_ID  = 1'b0;
         Write_ID_EX  = 1'b0;
         Write_EX_MEM = 1'b0;
         Write_MEM_WB = 1'b0;
         flush_IF_ID  = 1'b1;
         ctrlFlush    = 1'b1;
      end else if (w_dwait) begin
         PCWrite      = 1'b0;
         Write_IF_ID  = 1'b0;
         Write_ID_EX  = 1'b0;
         Write_EX_MEM = 1'b0;
         Write_MEM_WB = 1'b0;
      end else if (branch_taken_EX) begin
         flush_IF_ID  = 1'b1;
         ctrlFlush    = 1'b1;
      end else if (w_lu_stall) begin
         PCWrite      = 1'b0;
         Write_IF_ID  = 1'b0;
         ctrlFlush    = 1'b1;
      end else if (!ihit) begin
         PCWrite      = 1'b0;
         flush_IF_ID  = 1'b1;
      end
   end

   // A freeze holds state and cnt, so dwait cycles stretch a stall without consuming it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= RUN;
         r_cnt       <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (!PCWrite)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_dwait) begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
         end else if (branch_taken_EX) begin
            r_state <= RUN;
            r_cnt   <= '0;
         end else if (r_state == LU_STALL) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1))
               r_state <= RUN;
         end else if (w_lu_hit && (LOAD_LAT > 1)) begin
            r_state <= LU_STALL;
            r_cnt   <= LAT_M1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule
